// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types and constants.
// Used by pipe_slot and pipe_stage_skid.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY,
    PS_ONE,
    PS_FULL
  } pipe_state_e;

  localparam int INS_W   = 32;
  localparam int PC_W    = 64;
  localparam int IF_ID_W = INS_W + PC_W;

  localparam logic [INS_W-1:0] NOP_INS = 32'h0000_0013;

  localparam int PERF_CNT_W = 32;

  function automatic pipe_state_e state_of(
    input logic main_v,
    input logic skid_v
  );
    if (skid_v)
      return PS_FULL;
    else if (main_v)
      return PS_ONE;
    else
      return PS_EMPTY;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One held beat: a valid bit plus a payload register.
// Clear beats load; zero selects whether clear also wipes the payload.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int DATA_W = IF_ID_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic              zero,
  input  logic [DATA_W-1:0] d,
  output logic              valid,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      if (zero)
        q <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Reusable valid/ready pipeline stage with a 2-entry skid buffer.
// Define PIPE_STAGE_PERF_EN to add stall/flush/bubble counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int              DATA_W     = IF_ID_W,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = '0,
  parameter bit              FLUSH_ZERO = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_flush,
  input  logic              i_hold,
  input  logic              i_bubble,
  input  logic              i_up_valid,
  output logic              o_up_ready,
  input  logic [DATA_W-1:0] i_up_data,
  output logic              o_dn_valid,
  input  logic              i_dn_ready,
  output logic [DATA_W-1:0] o_dn_data,
`ifdef PIPE_STAGE_PERF_EN
  output logic [PERF_CNT_W-1:0] o_stall_cnt,
  output logic [PERF_CNT_W-1:0] o_flush_cnt,
  output logic [PERF_CNT_W-1:0] o_bubble_cnt,
`endif
  output logic [1:0]        o_occupancy
);

  logic              main_v, skid_v;
  logic [DATA_W-1:0] main_d, skid_d;
  logic [DATA_W-1:0] payload, main_din;
  logic              main_ld, main_clr;
  logic              skid_ld, skid_clr;
  logic              up_fire, dn_fire, zero;
  pipe_state_e       st;

  assign st         = state_of(main_v, skid_v);
  assign o_up_ready = ~skid_v & ~i_hold;
  assign o_dn_valid = main_v;
  assign o_dn_data  = main_d;
  assign up_fire    = i_up_valid & o_up_ready & ~i_flush;
  assign dn_fire    = main_v & i_dn_ready;
  assign payload    = i_bubble ? BUBBLE_VAL : i_up_data;
  assign zero       = i_flush & FLUSH_ZERO;
  assign o_occupancy = {1'b0, main_v} + {1'b0, skid_v};

  always_comb begin
    main_ld  = 1'b0;
    main_clr = 1'b0;
    skid_ld  = 1'b0;
    skid_clr = 1'b0;
    main_din = payload;
    if (i_flush) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (st)
        PS_EMPTY: main_ld = up_fire;
        PS_ONE: begin
          if (up_fire && dn_fire)
            main_ld = 1'b1;
          else if (up_fire)
            skid_ld = 1'b1;
          else if (dn_fire)
            main_clr = 1'b1;
        end
        PS_FULL: begin
          // drain: skid moves forward, keeping FIFO order
          if (dn_fire) begin
            main_ld  = 1'b1;
            main_din = skid_d;
            skid_clr = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  pipe_slot #(.DATA_W(DATA_W)) u_main (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .load  (main_ld),
    .clear (main_clr),
    .zero  (zero),
    .d     (main_din),
    .valid (main_v),
    .q     (main_d)
  );

  pipe_slot #(.DATA_W(DATA_W)) u_skid (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .load  (skid_ld),
    .clear (skid_clr),
    .zero  (zero),
    .d     (payload),
    .valid (skid_v),
    .q     (skid_d)
  );

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [PERF_CNT_W-1:0] CNT_ONE = 1;

  // saturating; flush never clears these
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_stall_cnt  <= '0;
      o_flush_cnt  <= '0;
      o_bubble_cnt <= '0;
    end else begin
      if (main_v && !i_dn_ready && o_stall_cnt != '1)
        o_stall_cnt <= o_stall_cnt + CNT_ONE;
      if (i_flush && o_flush_cnt != '1)
        o_flush_cnt <= o_flush_cnt + CNT_ONE;
      if (up_fire && i_bubble && o_bubble_cnt != '1)
        o_bubble_cnt <= o_bubble_cnt + CNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid against a queue-based model.
// Covers PIPE_STAGE_PERF_EN counters when that macro is defined.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int W = IF_ID_W;
  localparam logic [W-1:0] BUB = {{(W-INS_W){1'b0}}, NOP_INS};

  logic         clk = 1'b0;
  logic         rst_n, flush, hold, bubble;
  logic         up_valid, up_ready, dn_valid, dn_ready;
  logic [W-1:0] up_data, dn_data;
  logic [1:0]   occupancy;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]  stall_cnt, flush_cnt, bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] hold_q[$];
  logic [W-1:0] exp_q[$];
  logic         stall_prev = 1'b0;
  logic [W-1:0] prev_data;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DATA_W     (W),
    .BUBBLE_VAL (BUB),
    .FLUSH_ZERO (1'b1)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_flush      (flush),
    .i_hold       (hold),
    .i_bubble     (bubble),
    .i_up_valid   (up_valid),
    .o_up_ready   (up_ready),
    .i_up_data    (up_data),
    .o_dn_valid   (dn_valid),
    .i_dn_ready   (dn_ready),
    .o_dn_data    (dn_data),
`ifdef PIPE_STAGE_PERF_EN
    .o_stall_cnt  (stall_cnt),
    .o_flush_cnt  (flush_cnt),
    .o_bubble_cnt (bubble_cnt),
`endif
    .o_occupancy  (occupancy)
  );

  task automatic chk(input string name, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference model: the stage is a FIFO of capacity 2.
  always @(negedge clk) begin
    logic m_ready;
    if (!rst_n) begin
      hold_q.delete();
      exp_q.delete();
    end else begin
      m_ready = (hold_q.size() < 2) && !hold;
      chk("occupancy", W'(occupancy), W'(hold_q.size()));
      chk("up_ready", W'(up_ready), W'(m_ready));
      chk("dn_valid", W'(dn_valid), W'(hold_q.size() != 0));
      if (hold_q.size() != 0 && dn_ready)
        exp_q.push_back(hold_q.pop_front());
      if (flush)
        hold_q.delete();
      else if (up_valid && m_ready)
        hold_q.push_back(bubble ? BUB : up_data);
    end
  end

  // Monitor: compares every beat the DUT hands downstream.
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (dn_valid && dn_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dn_unexpected got %h expected none", dn_data);
        end else begin
          chk("dn_data", dn_data, exp_q.pop_front());
        end
      end
      if (exp_q.size() != 0) begin
        checks++;
        errors++;
        $display("FAIL dn_missing got none expected %h", exp_q[0]);
        exp_q.delete();
      end
      if (stall_prev) begin
        chk("dn_stable_v", W'(dn_valid), W'(1));
        chk("dn_stable_d", dn_data, prev_data);
      end
      stall_prev = dn_valid && !dn_ready && !flush;
      prev_data  = dn_data;
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    hold     = 1'b0;
    bubble   = 1'b0;
    dn_ready = 1'b0;
    up_valid = 1'b1;
    up_data  = W'(8'hAA);
    tick;
    tick;
    chk("rst_dn_valid", W'(dn_valid), '0);
    chk("rst_dn_data", dn_data, '0);
    chk("rst_occ", W'(occupancy), '0);
    rst_n    = 1'b1;
    up_valid = 1'b0;
    #1;
    chk("rst_up_ready", W'(up_ready), W'(1));

    dn_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      up_valid = 1'b1;
      up_data  = W'(i);
      tick;
      if (i == 1) begin
        chk("lat_dn_valid", W'(dn_valid), W'(1));
        chk("lat_dn_data", dn_data, W'(1));
      end
    end
    up_valid = 1'b0;
    tick;

    dn_ready = 1'b0;
    up_valid = 1'b1;
    up_data  = W'(8'h10);
    tick;
    up_data  = W'(8'h11);
    tick;
    chk("skid_occ", W'(occupancy), W'(2));
    chk("skid_up_ready", W'(up_ready), '0);
    up_data  = W'(8'h12);
    tick;
    dn_ready = 1'b1;
    tick;
    tick;
    up_valid = 1'b0;
    tick;
    tick;

    dn_ready = 1'b0;
    up_valid = 1'b1;
    up_data  = W'(8'h30);
    tick;
    up_data  = W'(8'h31);
    tick;
    up_data  = W'(8'h20);
    flush    = 1'b1;
    tick;
    flush    = 1'b0;
    up_valid = 1'b0;
    chk("flush_dn_valid", W'(dn_valid), '0);
    chk("flush_occ", W'(occupancy), '0);
    chk("flush_dn_data", dn_data, '0);
    tick;

    up_valid = 1'b1;
    up_data  = W'(8'h55);
    bubble   = 1'b1;
    tick;
    chk("bubble_data", dn_data, BUB);
    bubble   = 1'b0;
    up_data  = W'(8'h56);
    tick;
    hold     = 1'b1;
    dn_ready = 1'b1;
    tick;
    chk("hold_occ", W'(occupancy), W'(1));
    chk("hold_up_ready", W'(up_ready), '0);
    hold     = 1'b0;
    #1;
    chk("unhold_up_ready", W'(up_ready), W'(1));
    up_valid = 1'b0;
    tick;
    tick;

    repeat (600) begin
      up_valid = ($urandom % 4) != 0;
      up_data  = {$urandom, $urandom, $urandom};
      dn_ready = ($urandom % 3) != 0;
      flush    = ($urandom % 20) == 0;
      hold     = ($urandom % 6) == 0;
      bubble   = ($urandom % 8) == 0;
      tick;
    end
    up_valid = 1'b0;
    flush    = 1'b0;
    hold     = 1'b0;
    bubble   = 1'b0;
    dn_ready = 1'b1;
    repeat (3) tick;

`ifdef PIPE_STAGE_PERF_EN
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("perf_rst_stall", W'(stall_cnt), '0);
    chk("perf_rst_flush", W'(flush_cnt), '0);
    chk("perf_rst_bubble", W'(bubble_cnt), '0);
    up_valid = 1'b1;
    bubble   = 1'b1;
    dn_ready = 1'b1;
    repeat (3) begin
      up_data = {$urandom, $urandom, $urandom};
      tick;
    end
    up_valid = 1'b0;
    bubble   = 1'b0;
    dn_ready = 1'b0;
    repeat (5) tick;
    flush    = 1'b1;
    dn_ready = 1'b1;
    tick;
    tick;
    flush    = 1'b0;
    chk("perf_stall", W'(stall_cnt), W'(5));
    chk("perf_flush", W'(flush_cnt), W'(2));
    chk("perf_bubble", W'(bubble_cnt), W'(3));
    tick;
`endif

    chk("final_drained", W'(hold_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
